// File: rtl/key_debounce_array.sv
// Purpose: N-channel key debouncer with press/release/long-press pulse outputs.
// Latency: 3 cycles key_i->key_o in leading-edge mode, TIME+3 in stable-wait mode.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
module key_debounce_array #(
    parameter int N          = 4,
    parameter int TIME       = 240000,
    parameter int BITS       = 20,
    parameter int MODE       = 0,
    parameter int ACTIVE_LOW = 0,
    parameter int LONG_TIME  = 0,
    parameter int LBITS      = 24
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [N-1:0] key_i,
    output logic [N-1:0] key_o,
    output logic [N-1:0] press_p,
    output logic [N-1:0] release_p,
    output logic [N-1:0] long_p
);

    // Level meaning "released" / "pressed" after polarity is applied.
    localparam logic REL = (ACTIVE_LOW != 0);
    localparam logic PRS = (ACTIVE_LOW == 0);

    // Last value the debounce counter reaches before the window closes.
    localparam logic [BITS-1:0] CNT_END = BITS'(TIME - 1);

    // Hold counter saturation point and the value one cycle before it.
    localparam bit               LONG_EN  = (LONG_TIME != 0);
    localparam logic [LBITS-1:0] HOLD_END = LBITS'(LONG_TIME);
    localparam logic [LBITS-1:0] HOLD_PRE = LBITS'((LONG_TIME == 0) ? 0 : LONG_TIME - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    for (genvar n = 0; n < N; n++) begin : g_ch
        logic            sync1;
        logic            key_s;
        state_t          state;
        state_t          state_nxt;
        logic [BITS-1:0] count;
        logic [BITS-1:0] count_nxt;
        logic            key_q;
        logic            key_nxt;
        logic            press_q;
        logic            release_q;
        logic            long_q;

        // Two-flop synchroniser for the raw asynchronous key level.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                sync1 <= REL;
                key_s <= REL;
            end else begin
                sync1 <= key_i[n];
                key_s <= sync1;
            end
        end

        // State, counter, debounced level and edge pulses; pulses align with key_q change.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                state     <= ST_IDLE;
                count     <= '0;
                key_q     <= REL;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                count     <= count_nxt;
                key_q     <= key_nxt;
                press_q   <= (key_nxt == PRS) && (key_q != PRS);
                release_q <= (key_nxt == REL) && (key_q != REL);
            end
        end

        // Next-state: leading-edge takes the change then locks out; stable-wait commits after the window.
        always_comb begin
            state_nxt = state;
            count_nxt = count;
            key_nxt   = key_q;
            case (state)
                ST_IDLE: begin
                    if (key_s != key_q) begin
                        count_nxt = '0;
                        if (MODE == 0) begin
                            key_nxt   = key_s;
                            state_nxt = ST_LOCK;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_LOCK: begin
                    // Input is ignored; counter holds at its end value rather than wrapping.
                    if (count == CNT_END) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (key_s == key_q) begin
                        state_nxt = ST_IDLE;
                    end else if (count == CNT_END) begin
                        key_nxt   = key_s;
                        state_nxt = ST_IDLE;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        if (LONG_EN) begin : g_long
            logic [LBITS-1:0] hold;

            // Hold counter runs while pressed and saturates; long pulse fires as it reaches the threshold.
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    hold   <= '0;
                    long_q <= 1'b0;
                end else if (key_q == REL) begin
                    hold   <= '0;
                    long_q <= 1'b0;
                end else begin
                    if (hold != HOLD_END) begin
                        hold <= hold + 1'b1;
                    end
                    long_q <= (hold == HOLD_PRE);
                end
            end
        end else begin : g_no_long
            assign long_q = 1'b0;
        end

        assign key_o[n]     = key_q;
        assign press_p[n]   = press_q;
        assign release_p[n] = release_q;
        assign long_p[n]    = long_q;
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Purpose: scoreboard bench for key_debounce_array in leading-edge and stable-wait modes.
// Latency: expected pulse cycles are hand-computed from the raw key change cycle.
// Backpressure: none; the monitor samples every falling edge.
module tb_key_debounce_array;

    typedef struct packed {
        int         cyc;
        logic [1:0] kind;   // 0 press, 1 release, 2 long
    } ev_t;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] k0, k1;
    logic [1:0] ko0, pp0, rp0, lp0;
    logic [1:0] ko1, pp1, rp1, lp1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Queue index = dut*2 + channel.
    ev_t        sbq [4][$];
    logic [2:0] pv  [4];

    key_debounce_array #(
        .N(2), .TIME(8), .BITS(4), .MODE(0), .ACTIVE_LOW(0), .LONG_TIME(20), .LBITS(5)
    ) dut0 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_i     (k0),
        .key_o     (ko0),
        .press_p   (pp0),
        .release_p (rp0),
        .long_p    (lp0)
    );

    key_debounce_array #(
        .N(2), .TIME(8), .BITS(4), .MODE(1), .ACTIVE_LOW(0), .LONG_TIME(20), .LBITS(5)
    ) dut1 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_i     (k1),
        .key_o     (ko1),
        .press_p   (pp1),
        .release_p (rp1),
        .long_p    (lp1)
    );

    assign pv[0] = {lp0[0], rp0[0], pp0[0]};
    assign pv[1] = {lp0[1], rp0[1], pp0[1]};
    assign pv[2] = {lp1[0], rp1[0], pp1[0]};
    assign pv[3] = {lp1[1], rp1[1], pp1[1]};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic expect_ev(input int qi, input int c, input logic [1:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sbq[qi].push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every pulse pops the next expected event of its channel; overdue events are misses.
    always @(negedge sys_clk) begin
        ev_t e;
        for (int qi = 0; qi < 4; qi++) begin
            for (int k = 0; k < 3; k++) begin
                if (pv[qi][k] === 1'b1) begin
                    checks++;
                    if (sbq[qi].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse q%0d: got kind %0d at cycle %0d, required no pulse",
                                 qi, k, cyc);
                    end else begin
                        e = sbq[qi].pop_front();
                        if (e.cyc != cyc || int'(e.kind) != k) begin
                            errors++;
                            $display("FAIL pulse q%0d: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                     qi, k, cyc, e.kind, e.cyc);
                        end
                    end
                end
            end
            while (sbq[qi].size() != 0 && sbq[qi][0].cyc < cyc) begin
                e = sbq[qi].pop_front();
                checks++;
                errors++;
                $display("FAIL missed_pulse q%0d: got nothing, required kind %0d at cycle %0d",
                         qi, e.kind, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        sys_rst = 1'b1;
        k0      = 2'b00;
        k1      = 2'b00;
        tick(3);
        chk("rst_ko0", {30'd0, ko0}, 32'd0);
        chk("rst_pulses0", {26'd0, pp0, rp0, lp0}, 32'd0);
        chk("rst_ko1", {30'd0, ko1}, 32'd0);
        chk("rst_pulses1", {26'd0, pp1, rp1, lp1}, 32'd0);
        sys_rst = 1'b0;
        tick(4);
        chk("idle_ko0", {30'd0, ko0}, 32'd0);
        chk("idle_ko1", {30'd0, ko1}, 32'd0);

        // Leading-edge with bounce; release is seen during lockout and taken right after it ends.
        t = cyc;
        expect_ev(0, t + 3, 2'd0);
        expect_ev(0, t + 12, 2'd1);
        k0[0] = 1'b1;
        goto(t + 1); k0[0] = 1'b0;
        goto(t + 2); k0[0] = 1'b1;
        goto(t + 3); k0[0] = 1'b0;
        goto(t + 4); k0[0] = 1'b1;
        goto(t + 5); k0[0] = 1'b0;
        goto(t + 8);
        chk("lockout_ko0", {31'd0, ko0[0]}, 32'd1);
        goto(t + 13);
        chk("after_lock_ko0", {31'd0, ko0[0]}, 32'd0);
        goto(t + 30);

        // Stable-wait: one short glitch cancels the wait, then stable press commits TIME+3 later.
        t = cyc;
        expect_ev(2, t + 16, 2'd0);
        expect_ev(2, t + 31, 2'd1);
        k1[0] = 1'b1;
        goto(t + 4); k1[0] = 1'b0;
        goto(t + 5); k1[0] = 1'b1;
        goto(t + 15);
        chk("wait_pending_ko1", {31'd0, ko1[0]}, 32'd0);
        goto(t + 16);
        chk("wait_commit_ko1", {31'd0, ko1[0]}, 32'd1);
        goto(t + 20); k1[0] = 1'b0;
        goto(t + 45);

        // Long hold on channel 1, release, then a short re-press without long pulse.
        t = cyc;
        expect_ev(1, t + 3, 2'd0);
        expect_ev(1, t + 23, 2'd2);
        expect_ev(1, t + 43, 2'd1);
        expect_ev(1, t + 63, 2'd0);
        expect_ev(1, t + 73, 2'd1);
        k0[1] = 1'b1;
        goto(t + 40); k0[1] = 1'b0;
        goto(t + 60); k0[1] = 1'b1;
        goto(t + 70); k0[1] = 1'b0;
        goto(t + 90);

        // Simultaneous press on both channels, then independent releases.
        t = cyc;
        expect_ev(0, t + 3, 2'd0);
        expect_ev(0, t + 23, 2'd2);
        expect_ev(0, t + 33, 2'd1);
        expect_ev(1, t + 3, 2'd0);
        expect_ev(1, t + 23, 2'd2);
        expect_ev(1, t + 38, 2'd1);
        k0 = 2'b11;
        goto(t + 3);
        chk("simul_press", {30'd0, pp0}, 32'd3);
        goto(t + 30); k0[0] = 1'b0;
        goto(t + 34);
        chk("independent_ko0", {30'd0, ko0}, 32'd2);
        goto(t + 35); k0[1] = 1'b0;
        goto(t + 60);

        // Reset mid-hold abandons the long pulse; held key is a fresh press after reset.
        t = cyc;
        expect_ev(1, t + 3, 2'd0);
        k0[1] = 1'b1;
        goto(t + 18); sys_rst = 1'b1;
        goto(t + 19);
        chk("midhold_rst_ko0", {30'd0, ko0}, 32'd0);
        chk("midhold_rst_pulses0", {26'd0, pp0, rp0, lp0}, 32'd0);
        goto(t + 21);
        sys_rst = 1'b0;
        expect_ev(1, t + 24, 2'd0);
        expect_ev(1, t + 44, 2'd2);
        expect_ev(1, t + 53, 2'd1);
        goto(t + 23);
        chk("post_rst_ko0", {30'd0, ko0}, 32'd0);
        goto(t + 50); k0[1] = 1'b0;
        goto(t + 70);

        tick(5);
        for (int qi = 0; qi < 4; qi++) begin
            checks++;
            if (sbq[qi].size() != 0) begin
                errors++;
                $display("FAIL leftover q%0d: got %0d pending events, required 0", qi, sbq[qi].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter N, default 4: number of independent key channels (1..32).
REQ-002 Parameter TIME, default 240000: debounce window in sys_clk cycles (>=2).
REQ-003 Parameter BITS, default 20: debounce counter width; the design SHALL satisfy 2^BITS >= TIME.
REQ-004 Parameter MODE, default 0: 0 = leading-edge (output follows first change, then lockout); 1 = stable-wait (output changes only after TIME stable cycles).
REQ-005 Parameter ACTIVE_LOW, default 0: 1 = pressed level is 0.
REQ-006 Parameter LONG_TIME, default 0: long-press threshold in cycles; 0 disables long-press.
REQ-007 Parameter LBITS, default 24: hold counter width; the design SHALL satisfy 2^LBITS > LONG_TIME.
REQ-008 sys_clk  input  1  system clock; the only clock in the block, all logic on its rising edge.
REQ-009 sys_rst  input  1  reset, synchronous, active-high.
REQ-010 key_i  input  N  raw asynchronous key levels, one bit per channel.
REQ-011 key_o  output  N  debounced key levels, registered.
REQ-012 press_p  output  N  one-cycle pulse per channel on debounced transition to the pressed level.
REQ-013 release_p  output  N  one-cycle pulse per channel on debounced transition to the released level.
REQ-014 long_p  output  N  one-cycle pulse per channel when hold time reaches LONG_TIME.

Function
REQ-015 Each key_i bit SHALL pass a 2-flop synchroniser (key_s); all further logic uses key_s only.
REQ-016 Channels SHALL be fully independent, each with its own state, BITS counter and LBITS hold counter.
REQ-017 MODE=0 states IDLE and LOCK. In IDLE with key_s != key_o, the next edge sets key_o <= key_s, count <= 0 and state LOCK.
REQ-018 MODE=0 LOCK: count increments each cycle and key_s is ignored; at count == TIME-1 the state returns to IDLE.
REQ-019 MODE=0: key_o toggles at most once per TIME+1 cycles. A mismatch still present on return to IDLE SHALL be taken on the next edge.
REQ-020 MODE=1 states IDLE and WAIT. In IDLE with key_s != key_o, the state moves to WAIT with count <= 0.
REQ-021 MODE=1 WAIT: if key_s == key_o, return to IDLE (bounce cancelled; key_o unchanged). Otherwise count increments; at count == TIME-1, key_o <= key_s and return to IDLE.
REQ-022 press_p[n] SHALL be high exactly in the cycle key_o[n] first shows the pressed level. release_p[n] SHALL be high exactly in the cycle key_o[n] first shows the released level. The two are never both high on one channel.
REQ-023 Hold counter: cleared while key_o[n] is released; increments each cycle while pressed, saturating at LONG_TIME.
REQ-024 long_p[n] SHALL pulse in the cycle the hold counter reaches LONG_TIME, exactly once per press, and never when LONG_TIME == 0.
REQ-025 A release and re-press SHALL restart the hold count from 0.
REQ-026 Latency from a stable key_i change to key_o: 3 cycles in MODE=0; TIME+3 cycles in MODE=1 (from an idle channel).
REQ-027 Counters SHALL never wrap; count is cleared on every transition into LOCK or WAIT.

Reset
REQ-028 While sys_rst is high at a clock edge, every channel SHALL be forced to:
- synchroniser flops and key_o = released level (ACTIVE_LOW ? 1 : 0);
- state IDLE;
- count = 0 and hold counter = 0;
- press_p, release_p, long_p = 0.
REQ-029 Reset asserted mid-LOCK, mid-WAIT or mid-hold SHALL abandon the operation with no pulse emitted. The first clock after release behaves as IDLE.
REQ-030 If key_i is at the pressed level when reset releases, it SHALL be treated as a new press (press_p after normal latency).

Verification
REQ-031 Bench parameters: N=2, TIME=8, BITS=4, LONG_TIME=20, LBITS=5, ACTIVE_LOW=0.
REQ-032 MODE=0: key_i[0] 0->1 then bounces 1/0/1 over 5 cycles -> key_o[0]=1 and press_p[0] at cycle 3; no further toggles until the lockout ends; final level tracked afterwards.
REQ-033 MODE=1: key_i[0] 0->1 for 4 cycles, 0 for 1, then stable 1 -> key_o[0] rises 11 cycles after the final rising edge; single press_p[0].
REQ-034 Hold key_i[1]=1 for 40 cycles -> exactly one long_p[1], 20 cycles after press_p[1]. Release -> release_p[1]. Re-press for 10 cycles -> no long_p.
REQ-035 Simultaneous: key_i = 2'b11 in one cycle -> press_p = 2'b11 in the same cycle; channels independent thereafter.
REQ-036 Reset asserted at hold count 15 with key_i[1]=1 -> outputs cleared, no long_p. After reset releases: press_p[1] after 3 cycles, long_p[1] 20 cycles later.
